disp_sched: RTL and testbench
=============================

# disp_sched

Display page scheduler for the 4-digit seven-segment front panel. Time-shares the 16-bit visible window between up to four 32-bit CPU debug sources (e.g. PC, instruction, ALU result, memory data), each shown as a low and a high half. Drives the word and `lowOrHigh` select into the digit driver, and provides its digit-scan tick.

## Interface
- `DWELL_CYC`, 50_000_000: cycles each page is shown in auto mode (≥2).
- `SCAN_DIV`, 50_000: period of `scan_tick_o` in cycles (≥2).
- `DEBOUNCE_CYC`, 1_000_000: stable cycles required on `step_i`; used only with `DISP_SCHED_DEBOUNCE_EN`.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `src_i`  in  128  four sources; source k at `[32k+31:32k]`.
- `src_vld_i`  in  4  per-source enable; disabled sources are skipped.
- `mode_i`  in  1  0 = auto rotate, 1 = manual step.
- `step_i`  in  1  raw push-button, asynchronous to `clk`.
- `freeze_i`  in  1  hold the current page; no advance in either mode.
- `disp_data_o`  out  32  registered copy of the selected source.
- `low_high_o`  out  1  0 = show `[15:0]`, 1 = show `[31:16]`; feeds the driver's `lowOrHigh`.
- `page_o`  out  3  `{src[1:0], half}` currently shown.
- `blank_o`  out  1  1 when no source is enabled.
- `scan_tick_o`  out  1  one-cycle pulse every `SCAN_DIV` cycles.

## Operation
- Reset values: `disp_data_o`=0, `low_high_o`=0, `page_o`=0, `blank_o`=1, `scan_tick_o`=0. All counters are 0 and the FSM is in EMPTY.
- FSM has two states:
  - EMPTY: entered when `src_vld_i`==0. Outputs are forced to 0 and `blank_o`=1.
  - SHOW: entered when any `src_vld_i` bit is set. The source becomes the lowest enabled index and half=0.
- Page order is src low, then src high, then the next enabled source low.
- Next enabled source: search src+1, src+2, src+3, src, with wrap-around. A single enabled source alternates its two halves.
- Advance event:
  - Auto mode: dwell counter reaches `DWELL_CYC-1`. The counter then clears.
  - Manual mode: conditioned step rising edge. The dwell counter is held at 0.
  - `freeze_i`=1 suppresses both advance sources. The dwell counter holds its value.
  - A step edge that arrives during freeze is discarded, not queued.
- Any change of `mode_i` clears the dwell counter.
- Priority: if the current source's enable drops while in SHOW, jump on the next edge to the next enabled source, half=0. This happens even under freeze and overrides any coincident advance.
- `disp_data_o` <= `src_i` slice of the page's source every cycle, so live values track while the page is held.
- `low_high_o` = page half (registered).
- Step conditioning always uses a 2-FF synchronizer, then a rising-edge detect.
- The scan counter free-runs from reset, independent of mode, freeze and FSM state.

## Timing
- A source value change appears on `disp_data_o` one clock later.
- An advance event at edge N updates `page_o` and `low_high_o` at edge N. `disp_data_o` reflects the new source at edge N+1.
- Auto mode: page period is exactly `DWELL_CYC` cycles.
- Manual mode without debounce: `step_i` rising before edge 1 makes `page_o` change at edge 3.
- `scan_tick_o` is high for 1 cycle at cycles `SCAN_DIV-1`, `2·SCAN_DIV-1`, and so on.
- Reset mid-page returns immediately (asynchronously) to the reset values. The first page after release is shown for a full dwell.

## Configuration
- `DISP_SCHED_DEBOUNCE_EN` defined:
  - After the synchronizer, the step level must stay stable for `DEBOUNCE_CYC` consecutive cycles before it is accepted.
  - The edge detect runs on the accepted level.
  - Bounces shorter than `DEBOUNCE_CYC` produce no advance.
  - Added latency is `DEBOUNCE_CYC` cycles.
- Undefined: the synchronizer output drives the edge detect directly, and every synchronized rising edge advances.

## Structure
- `defines.v` gains the following constants:
  - page width
  - mode encodings
  - FSM state encodings (EMPTY, SHOW)
  - default dwell, scan and debounce counts
- Sub-module `disp_debounce` contains the synchronizer, the optional stability counter and the edge detect. Its output is a single-cycle `step_pulse`.
- The next-source search is a combinational function inside `disp_sched`.

## Test plan
- Auto rotation: `DWELL_CYC`=4, `src_vld_i`=4'b1111, sources 0x1111_0000 / 0x3333_2222 / 0x5555_4444 / 0x7777_6666.
  - Required: `page_o` steps 0,1,2,…,7,0, once every 4 cycles.
  - Required: `disp_data_o` matches each source one cycle after its page starts.
- Skip and wrap: `src_vld_i`=4'b1010, from page 3.
  - Required: sequence 3 → 6 → 7 → 2.
  - Then set `src_vld_i`=4'b0010. Required: 3 → 2 → 3 alternation.
- Enable drop: on page 6, clear `src_vld_i[3]` with `freeze_i`=1.
  - Required: `page_o`=2 on the next edge.
  - Then clear all enables. Required: `blank_o`=1 and outputs 0.
- Manual mode: `mode_i`=1, single clean `step_i` pulse (no debounce).
  - Required: exactly one advance, at edge 3.
  - A pulse issued while `freeze_i`=1 gives no advance, and none after freeze is released.
- Debounce build with `DEBOUNCE_CYC`=8:
  - Required: a 5-cycle glitch gives no advance.
  - Required: a 12-cycle press gives one advance after 2+8 cycles.
- Reset mid-dwell and scan:
  - Required: `rst`=0 forces all outputs to reset values within the same cycle.
  - Required: with `SCAN_DIV`=5, `scan_tick_o` fires at cycles 4, 9, 14.

Source files
------------

// File: rtl/disp_sched_pkg.sv
// Shared constants and encodings for the display page scheduler.
package disp_sched_pkg;

  localparam int unsigned PAGE_W  = 3;
  localparam int unsigned SRC_W   = 32;
  localparam int unsigned NUM_SRC = 4;

  localparam int unsigned DEF_DWELL_CYC    = 50_000_000;
  localparam int unsigned DEF_SCAN_DIV     = 50_000;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;

  typedef enum logic {
    MODE_AUTO   = 1'b0,
    MODE_MANUAL = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

endpackage

// File: rtl/disp_sched_if.sv
// Source bus in, display word/page out, between the CPU debug taps and the scheduler.
interface disp_sched_if;
  import disp_sched_pkg::*;

  logic [NUM_SRC*SRC_W-1:0] src_i;
  logic [NUM_SRC-1:0]       src_vld_i;
  logic [SRC_W-1:0]         disp_data_o;
  logic                     low_high_o;
  logic [PAGE_W-1:0]        page_o;
  logic                     blank_o;

  modport master (
    output src_i, src_vld_i,
    input  disp_data_o, low_high_o, page_o, blank_o
  );

  modport slave (
    input  src_i, src_vld_i,
    output disp_data_o, low_high_o, page_o, blank_o
  );

endinterface

// File: rtl/disp_sched_debounce.sv
// Step button conditioning: 2-FF synchronizer, optional stability filter, rising-edge pulse.
// Stability filter enabled by defining DISP_SCHED_DEBOUNCE_EN.
module disp_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic step_i,
  output logic step_pulse
);

`ifdef DISP_SCHED_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  localparam int unsigned     DB_W    = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  logic            acc_q, acc_d;
  logic            prev_q, prev_d;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level;

  always_comb begin
    sync1_d = step_i;
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (!DB_EN) begin
      acc_d = sync2_q;
      cnt_d = '0;
    end else if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == DB_LAST) begin
      // Level differed from the accepted one for DEBOUNCE_CYC straight cycles.
      acc_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    level      = DB_EN ? acc_q : sync2_q;
    prev_d     = level;
    step_pulse = level & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      acc_q   <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/disp_sched.sv
// Display page scheduler: rotates low/high halves of up to four 32-bit sources onto the panel.
// Optional step debounce via DISP_SCHED_DEBOUNCE_EN (see disp_debounce).
module disp_sched
  import disp_sched_pkg::*;
#(
  parameter int unsigned DWELL_CYC    = DEF_DWELL_CYC,
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
  input  logic         clk,
  input  logic         rst,
  disp_sched_if.slave  bus,
  input  logic         mode_i,
  input  logic         step_i,
  input  logic         freeze_i,
  output logic         scan_tick_o
);

  localparam int unsigned      DW_W       = $clog2(DWELL_CYC);
  localparam int unsigned      SC_W       = $clog2(SCAN_DIV);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYC - 1);
  localparam logic [SC_W-1:0]  SCAN_LAST  = SC_W'(SCAN_DIV - 1);

  function automatic logic [1:0] lowest_src(input logic [NUM_SRC-1:0] vld);
    logic found;
    lowest_src = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (vld[i] && !found) begin
        lowest_src = 2'(i);
        found      = 1'b1;
      end
    end
  endfunction

  // Search cur+1, cur+2, cur+3 with wrap; fall back to cur itself.
  function automatic logic [1:0] next_src(input logic [1:0] cur, input logic [NUM_SRC-1:0] vld);
    logic [1:0] cand;
    logic       found;
    next_src = cur;
    found    = 1'b0;
    for (int unsigned i = 1; i < NUM_SRC; i++) begin
      cand = cur + 2'(i);
      if (vld[cand] && !found) begin
        next_src = cand;
        found    = 1'b1;
      end
    end
  endfunction

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d, mode_in;
  logic [1:0]      src_q, src_d;
  logic            half_q, half_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [SRC_W-1:0] disp_data_q, disp_data_d;
  logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
  logic            scan_tick_q, scan_tick_d;
  logic            step_pulse;
  logic            adv;

  disp_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .step_i     (step_i),
    .step_pulse (step_pulse)
  );

  assign mode_in = mode_e'(mode_i);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_in;
    src_d   = src_q;
    half_d  = half_q;
    dwell_d = dwell_q;
    adv     = 1'b0;

    if (mode_in == MODE_MANUAL) begin
      dwell_d = '0;
      adv     = step_pulse && !freeze_i && (state_q == ST_SHOW);
    end else if (state_q == ST_SHOW && !freeze_i) begin
      if (dwell_q == DWELL_LAST) begin
        adv     = 1'b1;
        dwell_d = '0;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
    if (mode_in != mode_q) dwell_d = '0;

    // A dropped enable outranks freeze and any coincident advance.
    unique case (state_q)
      ST_EMPTY: begin
        dwell_d = '0;
        if (|bus.src_vld_i) begin
          state_d = ST_SHOW;
          src_d   = lowest_src(bus.src_vld_i);
          half_d  = 1'b0;
        end
      end
      ST_SHOW: begin
        if (bus.src_vld_i == '0) begin
          state_d = ST_EMPTY;
          src_d   = '0;
          half_d  = 1'b0;
          dwell_d = '0;
        end else if (!bus.src_vld_i[src_q]) begin
          src_d   = next_src(src_q, bus.src_vld_i);
          half_d  = 1'b0;
          dwell_d = '0;
        end else if (adv) begin
          if (!half_q) begin
            half_d = 1'b1;
          end else begin
            half_d = 1'b0;
            src_d  = next_src(src_q, bus.src_vld_i);
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    disp_data_d = (state_d == ST_EMPTY) ? '0 : bus.src_i[{src_q, 5'd0} +: SRC_W];

    scan_cnt_d  = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
    scan_tick_d = (scan_cnt_d == SCAN_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_EMPTY;
      mode_q      <= MODE_AUTO;
      src_q       <= '0;
      half_q      <= 1'b0;
      dwell_q     <= '0;
      disp_data_q <= '0;
      scan_cnt_q  <= '0;
      scan_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      src_q       <= src_d;
      half_q      <= half_d;
      dwell_q     <= dwell_d;
      disp_data_q <= disp_data_d;
      scan_cnt_q  <= scan_cnt_d;
      scan_tick_q <= scan_tick_d;
    end
  end

  assign bus.page_o      = {src_q, half_q};
  assign bus.low_high_o  = half_q;
  assign bus.blank_o     = (state_q == ST_EMPTY);
  assign bus.disp_data_o = disp_data_q;
  assign scan_tick_o     = scan_tick_q;

endmodule

// File: tb/tb_disp_sched.sv
// Directed, table-driven bench for disp_sched with small dwell/scan/debounce counts.
module tb_disp_sched;

  localparam logic [31:0] S0 = 32'h1111_0000;
  localparam logic [31:0] S1 = 32'h3333_2222;
  localparam logic [31:0] S2 = 32'h5555_4444;
  localparam logic [31:0] S3 = 32'h7777_6666;

  typedef struct {
    logic [3:0]  vld;
    logic        mode;
    logic        frz;
    logic        stp;
    logic [2:0]  page;
    logic        blank;
    logic [31:0] data;
    logic        chk;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode_i = 1'b0;
  logic step_i = 1'b0;
  logic freeze_i = 1'b0;
  logic scan_tick_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  vec_t        vecs[$];
  logic [31:0] srcs [4];

  disp_sched_if bus ();

  disp_sched #(
    .DWELL_CYC    (4),
    .SCAN_DIV     (5),
    .DEBOUNCE_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mode_i      (mode_i),
    .step_i      (step_i),
    .freeze_i    (freeze_i),
    .scan_tick_o (scan_tick_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int unsigned n, input logic [3:0] vld, input logic mode,
                     input logic frz, input logic stp, input logic [2:0] page,
                     input logic blank, input logic [31:0] data, input logic dchk);
    for (int unsigned i = 0; i < n; i++)
      vecs.push_back('{vld, mode, frz, stp, page, blank, data, dchk});
  endtask

  initial begin
    srcs[0] = S0; srcs[1] = S1; srcs[2] = S2; srcs[3] = S3;

    // Auto rotation over all four sources, edges 1..33
    for (int unsigned p = 0; p < 8; p++) begin
      add(1, 4'hF, 0, 0, 0, 3'(p), 0, '0, 0);
      add(3, 4'hF, 0, 0, 0, 3'(p), 0, srcs[p >> 1], 1);
    end
    add(1, 4'hF, 0, 0, 0, 3'd0, 0, '0, 0);
    // Skip and wrap with sources 1 and 3, then a single source
    add(1, 4'hA, 0, 0, 0, 3'd2, 0, '0, 0);
    add(3, 4'hA, 0, 0, 0, 3'd2, 0, S1, 1);
    add(4, 4'hA, 0, 0, 0, 3'd3, 0, S1, 1);
    add(1, 4'hA, 0, 0, 0, 3'd6, 0, '0, 0);
    add(3, 4'hA, 0, 0, 0, 3'd6, 0, S3, 1);
    add(4, 4'hA, 0, 0, 0, 3'd7, 0, S3, 1);
    add(1, 4'hA, 0, 0, 0, 3'd2, 0, '0, 0);
    add(3, 4'h2, 0, 0, 0, 3'd2, 0, S1, 1);
    add(4, 4'h2, 0, 0, 0, 3'd3, 0, S1, 1);
    add(4, 4'h2, 0, 0, 0, 3'd2, 0, S1, 1);
    add(4, 4'h2, 0, 0, 0, 3'd3, 0, S1, 1);
    // Enable drop under freeze, then all disabled
    add(1, 4'hA, 0, 0, 0, 3'd6, 0, '0, 0);
    add(1, 4'h2, 0, 1, 0, 3'd2, 0, '0, 0);
    add(3, 4'h2, 0, 1, 0, 3'd2, 0, S1, 1);
    add(2, 4'h0, 0, 0, 0, 3'd0, 1, '0, 1);
    // Manual mode: one step pulse, then a pulse swallowed by freeze
    add(1, 4'hF, 1, 0, 0, 3'd0, 0, '0, 0);
    add(7, 4'hF, 1, 0, 0, 3'd0, 0, S0, 1);
    add(1, 4'hF, 1, 0, 1, 3'd0, 0, S0, 1);
    add(1, 4'hF, 1, 0, 0, 3'd0, 0, S0, 1);
    add(5, 4'hF, 1, 0, 0, 3'd1, 0, S0, 1);
    add(1, 4'hF, 1, 1, 1, 3'd1, 0, S0, 1);
    add(3, 4'hF, 1, 1, 0, 3'd1, 0, S0, 1);
    add(4, 4'hF, 1, 0, 0, 3'd1, 0, S0, 1);

    bus.src_i     = {S3, S2, S1, S0};
    bus.src_vld_i = 4'hF;

    #2 rst = 1'b0;
    #1;
    chk("rst_page", 32'(bus.page_o), 32'd0);
    chk("rst_lh", 32'(bus.low_high_o), 32'd0);
    chk("rst_blank", 32'(bus.blank_o), 32'd1);
    chk("rst_data", bus.disp_data_o, 32'd0);
    chk("rst_scan", 32'(scan_tick_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      bus.src_vld_i = vecs[i].vld;
      mode_i        = vecs[i].mode;
      freeze_i      = vecs[i].frz;
      step_i        = vecs[i].stp;
      tick();
      chk($sformatf("vec%0d_page", i), 32'(bus.page_o), 32'(vecs[i].page));
      chk($sformatf("vec%0d_lh", i), 32'(bus.low_high_o), 32'(vecs[i].page[0]));
      chk($sformatf("vec%0d_blank", i), 32'(bus.blank_o), 32'(vecs[i].blank));
      if (vecs[i].chk)
        chk($sformatf("vec%0d_data", i), bus.disp_data_o, vecs[i].data);
    end

    // Asynchronous reset mid-dwell, then full first dwell and scan ticks
    mode_i = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_page", 32'(bus.page_o), 32'd0);
    chk("mid_rst_lh", 32'(bus.low_high_o), 32'd0);
    chk("mid_rst_blank", 32'(bus.blank_o), 32'd1);
    chk("mid_rst_data", bus.disp_data_o, 32'd0);
    chk("mid_rst_scan", 32'(scan_tick_o), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int unsigned n = 1; n <= 15; n++) begin
      tick();
      chk($sformatf("scan_e%0d", n), 32'(scan_tick_o), 32'((n % 5) == 4));
      chk($sformatf("post_rst_page_e%0d", n), 32'(bus.page_o), ((n - 1) / 4) % 8);
    end

    // Live tracking of a held page's source
    bus.src_i[63:32] = 32'hDEAD_BEEF;
    tick();
    chk("live_data", bus.disp_data_o, 32'hDEAD_BEEF);
    bus.src_i[63:32] = S1;

`ifdef DISP_SCHED_DEBOUNCE_EN
    mode_i = 1'b1;
    repeat (3) tick();
    step_i = 1'b1;
    repeat (5) tick();
    step_i = 1'b0;
    repeat (15) tick();
    chk("db_glitch_page", 32'(bus.page_o), 32'd3);
    step_i = 1'b1;
    for (int unsigned k = 1; k <= 12; k++) begin
      tick();
      if (k == 10) chk("db_before_page", 32'(bus.page_o), 32'd3);
      if (k == 11) chk("db_accept_page", 32'(bus.page_o), 32'd4);
    end
    step_i = 1'b0;
    repeat (15) tick();
    chk("db_release_page", 32'(bus.page_o), 32'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
